// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the DMEM arbiter, also used by the core LSU and host loader.
// Response-owner tags and default DMEM geometry.
package dmem_arb_pkg;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  localparam int unsigned DMEM_AW = 10;
  localparam int unsigned DMEM_DW = 32;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, host and DMEM buses around the DMEM arbiter.
// slave = arbiter view, master = environment view (core, host and DMEM together).
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW = DMEM_AW,
  parameter int unsigned DW = DMEM_DW
);

  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_resp.sv
// One-cycle read-response tag register; steers DMEM read data to the access owner.
// Non-owner port sees rvalid=0 and rdata=0.
module dmem_arb_resp
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_accept,
  input  logic          rd_owner,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata
);

  logic resp_pend_d, resp_pend_q;
  logic resp_owner_d, resp_owner_q;

  always_comb begin
    resp_pend_d  = rd_accept;
    resp_owner_d = rd_owner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pend_q  <= 1'b0;
      resp_owner_q <= OWNER_CORE;
    end else begin
      resp_pend_q  <= resp_pend_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Gating with rst drops a response whose read was accepted the cycle before reset.
  always_comb begin
    core_rvalid = resp_pend_q && !rst && (resp_owner_q == OWNER_CORE);
    host_rvalid = resp_pend_q && !rst && (resp_owner_q == OWNER_HOST);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port DMEM between the core LSU (fixed priority) and a host/debug port.
// A saturating wait counter lets a starved host win a conflict after HOST_MAX_WAIT cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW            = DMEM_AW,
  parameter int unsigned DW            = DMEM_DW,
  parameter int unsigned HOST_MAX_WAIT = 4,
  parameter int unsigned CW            = 3
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [CW-1:0] MAX_WAIT = CW'(HOST_MAX_WAIT);

  logic [CW-1:0] wait_cnt_d, wait_cnt_q;
  logic          host_win;
  logic          core_gnt;
  logic          host_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    host_win = (HOST_MAX_WAIT != 0) && (wait_cnt_q == MAX_WAIT);
    core_gnt = !rst && bus.core_req && !(bus.host_req && host_win);
    host_gnt = !rst && bus.host_req && (!bus.core_req || host_win);

    wait_cnt_d = wait_cnt_q;
    if (!bus.host_req || host_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (core_gnt) begin
      sel_we    = bus.core_we;
      sel_addr  = bus.core_addr;
      sel_wdata = bus.core_wdata;
    end else if (host_gnt) begin
      sel_we    = bus.host_we;
      sel_addr  = bus.host_addr;
      sel_wdata = bus.host_wdata;
    end
  end

  assign bus.core_gnt  = core_gnt;
  assign bus.host_gnt  = host_gnt;
  assign bus.mem_en    = core_gnt || host_gnt;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  dmem_arb_resp #(
    .DW(DW)
  ) u_resp (
    .clk        (clk),
    .rst        (rst),
    .rd_accept  ((core_gnt || host_gnt) && !sel_we),
    .rd_owner   (host_gnt ? OWNER_HOST : OWNER_CORE),
    .mem_rdata  (bus.mem_rdata),
    .core_rvalid(bus.core_rvalid),
    .core_rdata (bus.core_rdata),
    .host_rvalid(bus.host_rvalid),
    .host_rdata (bus.host_rdata)
  );

endmodule
